multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm_if.sv | 36 +++
 rtl/multicycle_control_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle controller and its datapath:
// instruction/handshake inputs to the controller and the strobes and selects it drives.
interface multicycle_control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       Branch;
    logic       IorD;
    logic       RegDst;
    logic       MemToReg;
    logic       Jal;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [1:0] ALUOp;
    logic [3:0] state;
    logic       halted;
    logic       instr_done;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemWrite, Branch, IorD, RegDst,
               MemToReg, Jal, ALUSrcA, ALUSrcB, PCSrc, ALUOp, state, halted,
               instr_done
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemWrite, Branch, IorD, RegDst,
               MemToReg, Jal, ALUSrcA, ALUSrcB, PCSrc, ALUOp, state, halted,
               instr_done
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control FSM: Moore decode of the state register, with
// FETCH/MEMWR strobes gated by mem_ready and every output forced low during reset.
module multicycle_control_fsm #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JAL    = 4'd11,
        S_JR     = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_PBYTE = 6'b011111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_JR    = 6'b000111;

    state_t     state_r;
    state_t     next_state_s;

    logic       pc_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       mem_write_s;
    logic       branch_s;
    logic       iord_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       jal_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] pc_src_s;
    logic [1:0] alu_op_s;
    logic [3:0] state_s;
    logic       halted_s;
    logic       instr_done_s;

    function automatic state_t decode_next(input logic [5:0] op, input bit halt_on_illegal);
        case (op)
            OP_RTYPE, OP_PBYTE: decode_next = S_EXEC;
            OP_LW, OP_SW:       decode_next = S_MEMADR;
            OP_BEQ:             decode_next = S_BRANCH;
            OP_ADDI:            decode_next = S_ADDIEX;
            OP_JAL:             decode_next = S_JAL;
            OP_JR:              decode_next = S_JR;
            default:            decode_next = halt_on_illegal ? S_HALT : S_FETCH;
        endcase
    endfunction

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection; memory states hold until mem_ready.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:  next_state_s = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: next_state_s = decode_next(bus.opcode, ILLEGAL_HALT);
            S_MEMADR: next_state_s = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state_s = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_state_s = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state_s = S_ALUWB;
            S_ADDIEX: next_state_s = S_ADDIWB;
            S_HALT:   next_state_s = S_HALT;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JAL, S_JR:
                      next_state_s = S_FETCH;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Output decode from state; everything is held low while reset is asserted.
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        branch_s     = 1'b0;
        iord_s       = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        jal_s        = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_src_s     = 2'b00;
        alu_op_s     = 2'b00;
        state_s      = 4'd0;
        halted_s     = 1'b0;
        instr_done_s = 1'b0;
        if (!reset) begin
            state_s = 4'd0;
        end else begin
            state_s = state_r;
            case (state_r)
                S_FETCH: begin
                    alu_src_b_s = 2'b01;
                    ir_write_s  = bus.mem_ready;
                    pc_write_s  = bus.mem_ready;
                end
                S_DECODE: begin
                    alu_src_b_s = 2'b11;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a_s = 1'b1;
                    alu_src_b_s = 2'b10;
                end
                S_MEMRD: begin
                    iord_s = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg_s = 1'b1;
                    reg_write_s  = 1'b1;
                    instr_done_s = 1'b1;
                end
                S_MEMWR: begin
                    iord_s       = 1'b1;
                    mem_write_s  = bus.mem_ready;
                    instr_done_s = bus.mem_ready;
                end
                S_EXEC: begin
                    alu_src_a_s = 1'b1;
                    alu_op_s    = (bus.opcode == OP_PBYTE) ? 2'b11 : 2'b10;
                end
                S_ALUWB: begin
                    reg_dst_s    = 1'b1;
                    reg_write_s  = 1'b1;
                    instr_done_s = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_s  = 1'b1;
                    alu_op_s     = 2'b01;
                    pc_src_s     = 2'b01;
                    branch_s     = 1'b1;
                    instr_done_s = 1'b1;
                end
                S_ADDIWB: begin
                    reg_write_s  = 1'b1;
                    instr_done_s = 1'b1;
                end
                S_JAL: begin
                    // PC already holds PC+4 here, so it is the link value.
                    jal_s        = 1'b1;
                    reg_write_s  = 1'b1;
                    pc_src_s     = 2'b10;
                    pc_write_s   = 1'b1;
                    instr_done_s = 1'b1;
                end
                S_JR: begin
                    pc_src_s     = 2'b11;
                    pc_write_s   = 1'b1;
                    instr_done_s = 1'b1;
                end
                S_HALT: begin
                    halted_s = 1'b1;
                end
                default: begin
                    halted_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.PCWrite    = pc_write_s;
    assign bus.IRWrite    = ir_write_s;
    assign bus.RegWrite   = reg_write_s;
    assign bus.MemWrite   = mem_write_s;
    assign bus.Branch     = branch_s;
    assign bus.IorD       = iord_s;
    assign bus.RegDst     = reg_dst_s;
    assign bus.MemToReg   = mem_to_reg_s;
    assign bus.Jal        = jal_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.PCSrc      = pc_src_s;
    assign bus.ALUOp      = alu_op_s;
    assign bus.state      = state_s;
    assign bus.halted     = halted_s;
    assign bus.instr_done = instr_done_s;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed scenarios then random traffic, both
// ILLEGAL_HALT settings checked every cycle against an instruction-plan model.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic       mem_ready;
    logic [5:0] opcode;

    int tests;
    int fails;

    multicycle_control_fsm_if bus0 ();
    multicycle_control_fsm_if bus1 ();

    assign bus0.opcode    = opcode;
    assign bus0.mem_ready = mem_ready;
    assign bus1.opcode    = opcode;
    assign bus1.mem_ready = mem_ready;

    multicycle_control_fsm #(.ILLEGAL_HALT(1'b1)) u_dut_halt (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    multicycle_control_fsm #(.ILLEGAL_HALT(1'b0)) u_dut_fetch (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,IRWrite,RegWrite,MemWrite,Branch,IorD,RegDst,MemToReg,Jal,ALUSrcA,
    //  ALUSrcB[1:0],PCSrc[1:0],ALUOp[1:0],state[3:0],halted,instr_done}
    logic [21:0] vec0, vec1;
    assign vec0 = {bus0.PCWrite, bus0.IRWrite, bus0.RegWrite, bus0.MemWrite, bus0.Branch,
                   bus0.IorD, bus0.RegDst, bus0.MemToReg, bus0.Jal, bus0.ALUSrcA,
                   bus0.ALUSrcB, bus0.PCSrc, bus0.ALUOp, bus0.state, bus0.halted, bus0.instr_done};
    assign vec1 = {bus1.PCWrite, bus1.IRWrite, bus1.RegWrite, bus1.MemWrite, bus1.Branch,
                   bus1.IorD, bus1.RegDst, bus1.MemToReg, bus1.Jal, bus1.ALUSrcA,
                   bus1.ALUSrcB, bus1.PCSrc, bus1.ALUOp, bus1.state, bus1.halted, bus1.instr_done};

    int          m_st [2];
    int          m_k  [2];
    logic [21:0] last_vec0, last_vec1;
    logic [21:0] seen [16];

    // States an instruction visits after DECODE, then back to FETCH (0).
    function automatic int plan_at(input logic [5:0] op, input bit ih, input int k);
        int s [4];
        s = '{0, 0, 0, 0};
        case (op)
            6'b100011:            s = '{2, 3, 4, 0};
            6'b101011:            s = '{2, 5, 0, 0};
            6'b000000, 6'b011111: s = '{6, 7, 0, 0};
            6'b000100:            s = '{8, 0, 0, 0};
            6'b001000:            s = '{9, 10, 0, 0};
            6'b000011:            s = '{11, 0, 0, 0};
            6'b000111:            s = '{12, 0, 0, 0};
            default:              if (ih) s = '{13, 0, 0, 0};
        endcase
        return (k >= 0 && k < 4) ? s[k] : 0;
    endfunction

    function automatic logic [21:0] exp_out(input int st, input bit mr, input logic [5:0] op, input bit rst);
        logic pcw, irw, rw, mw, br, iord, rd, m2r, jal, asa, hlt, done;
        logic [1:0] asb, pcs, aop;
        logic [3:0] s4;
        {pcw, irw, rw, mw, br, iord, rd, m2r, jal, asa, hlt, done} = 12'd0;
        asb = 2'd0; pcs = 2'd0; aop = 2'd0;
        s4  = st[3:0];
        if (!rst) return 22'd0;
        case (st)
            0:  begin asb = 2'd1; pcw = mr; irw = mr; end
            1:  asb = 2'd3;
            2:  begin asa = 1'b1; asb = 2'd2; end
            3:  iord = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
            5:  begin iord = 1'b1; mw = mr; done = mr; end
            6:  begin asa = 1'b1; aop = (op == 6'b011111) ? 2'd3 : 2'd2; end
            7:  begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'd1; pcs = 2'd1; br = 1'b1; done = 1'b1; end
            9:  begin asa = 1'b1; asb = 2'd2; end
            10: begin rw = 1'b1; done = 1'b1; end
            11: begin jal = 1'b1; rw = 1'b1; pcs = 2'd2; pcw = 1'b1; done = 1'b1; end
            12: begin pcs = 2'd3; pcw = 1'b1; done = 1'b1; end
            13: hlt = 1'b1;
            default: hlt = 1'b0;
        endcase
        return {pcw, irw, rw, mw, br, iord, rd, m2r, jal, asa, asb, pcs, aop, s4, hlt, done};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic advance(input int i, input bit ih);
        if (!reset) begin
            m_st[i] = 0;
        end else if (m_st[i] == 13) begin
            m_st[i] = 13;
        end else if ((m_st[i] == 0 || m_st[i] == 3 || m_st[i] == 5) && !mem_ready) begin
            m_st[i] = m_st[i];
        end else if (m_st[i] == 0) begin
            m_st[i] = 1;
        end else if (m_st[i] == 1) begin
            m_k[i]  = 0;
            m_st[i] = plan_at(opcode, ih, 0);
        end else begin
            m_k[i]  = m_k[i] + 1;
            m_st[i] = plan_at(opcode, ih, m_k[i]);
        end
    endtask

    // One cycle: check both instances against the model mid-cycle, then clock.
    task automatic step();
        @(negedge clk);
        last_vec0 = vec0;
        last_vec1 = vec1;
        check_eq("outputs_halt_inst", {10'd0, vec0}, {10'd0, exp_out(m_st[0], mem_ready, opcode, reset)});
        check_eq("outputs_fetch_inst", {10'd0, vec1}, {10'd0, exp_out(m_st[1], mem_ready, opcode, reset)});
        advance(0, 1'b1);
        advance(1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction with mem_ready high, final FETCH cycle with mem_ready low.
    task automatic run_seq(input string tag, input logic [5:0] op, input int n, input int exp_s [6]);
        opcode = op;
        reset  = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ready = (i == n - 1) ? 1'b0 : 1'b1;
            step();
            seen[last_vec0[5:2]] = last_vec0;
            check_eq(tag, {28'd0, last_vec0[5:2]}, exp_s[i]);
        end
    endtask

    int rw_cnt;
    int done_cnt;
    int ops [8];

    initial begin
        tests = 0; fails = 0;
        m_st = '{0, 0}; m_k = '{0, 0};
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b011111, 6'b000100, 6'b001000, 6'b000011, 6'b000111};
        reset = 1'b0; mem_ready = 1'b1; opcode = 6'b100011;

        // lw after a 2-cycle reset
        step();
        check_eq("reset_outputs_zero", {10'd0, last_vec0}, 32'd0);
        step();
        reset = 1'b1; rw_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = (i == 5) ? 1'b0 : 1'b1;
            step();
            rw_cnt   += int'(last_vec0[19]);
            done_cnt += int'(last_vec0[0]);
            check_eq("lw_state_seq", {28'd0, last_vec0[5:2]}, (i == 5) ? 32'd0 : i);
            if (last_vec0[19]) check_eq("lw_regwrite_state", {28'd0, last_vec0[5:2]}, 32'd4);
        end
        check_eq("lw_regwrite_count", rw_cnt, 32'd1);
        check_eq("lw_done_count", done_cnt, 32'd1);

        // sw with 3 wait cycles in MEMWR
        opcode = 6'b101011; mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("sw_wait_state", {28'd0, last_vec0[5:2]}, 32'd5);
            check_eq("sw_wait_memwrite", {31'd0, last_vec0[18]}, 32'd0);
        end
        mem_ready = 1'b1;
        step();
        check_eq("sw_memwrite_pulse", {31'd0, last_vec0[18]}, 32'd1);
        check_eq("sw_done_pulse", {31'd0, last_vec0[0]}, 32'd1);
        mem_ready = 1'b0;
        step();
        check_eq("sw_back_to_fetch", {28'd0, last_vec0[5:2]}, 32'd0);

        run_seq("jal_state_seq", 6'b000011, 4, '{0, 1, 11, 0, 0, 0});
        check_eq("jal_strobes", {28'd0, seen[11][21], seen[11][19], seen[11][13], 1'b0},
                 {28'd0, 4'b1110});
        check_eq("jal_pcsrc", {30'd0, seen[11][9:8]}, 32'd2);
        run_seq("pbyte_state_seq", 6'b011111, 5, '{0, 1, 6, 7, 0, 0});
        check_eq("pbyte_aluop", {30'd0, seen[6][7:6]}, 32'd3);
        check_eq("pbyte_regdst", {31'd0, seen[7][15]}, 32'd1);
        run_seq("rtype_state_seq", 6'b000000, 5, '{0, 1, 6, 7, 0, 0});
        check_eq("rtype_aluop", {30'd0, seen[6][7:6]}, 32'd2);
        check_eq("rtype_regdst", {31'd0, seen[7][15]}, 32'd1);
        run_seq("beq_state_seq", 6'b000100, 4, '{0, 1, 8, 0, 0, 0});
        run_seq("addi_state_seq", 6'b001000, 5, '{0, 1, 9, 10, 0, 0});
        run_seq("jr_state_seq", 6'b000111, 4, '{0, 1, 12, 0, 0, 0});

        // Illegal opcode: HALT on one instance, back to FETCH on the other
        opcode = 6'b111111; mem_ready = 1'b1;
        step(); step();
        check_eq("illegal_decode", {28'd0, last_vec1[5:2]}, 32'd1);
        step();
        check_eq("illegal_halt_state", {28'd0, last_vec0[5:2]}, 32'd13);
        check_eq("illegal_fetch_state", {28'd0, last_vec1[5:2]}, 32'd0);
        mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            step();
            check_eq("halt_no_strobes", {27'd0, last_vec0[21:18], last_vec0[1]}, 32'd1);
        end
        reset = 1'b0;
        step();
        reset = 1'b1; mem_ready = 1'b0;
        step();
        check_eq("halt_exit_by_reset", {27'd0, last_vec0[5:2], last_vec0[1]}, 32'd0);

        // Reset during the MEMRD wait
        opcode = 6'b100011; mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        step();
        check_eq("memrd_wait_state", {28'd0, last_vec0[5:2]}, 32'd3);
        reset = 1'b0; mem_ready = 1'b1;
        step();
        check_eq("reset_in_memrd_outputs", {10'd0, last_vec0}, 32'd0);
        reset = 1'b1; mem_ready = 1'b0;
        step();
        check_eq("reset_in_memrd_state", {28'd0, last_vec0[5:2]}, 32'd0);
        check_eq("reset_in_memrd_regwrite", {31'd0, last_vec0[19]}, 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ((m_st[0] == 0 || m_st[0] == 13) && (m_st[1] == 0 || m_st[1] == 13)) begin
                if ($urandom_range(0, 9) < 8) opcode = 6'(ops[$urandom_range(0, 7)]);
                else                          opcode = 6'($urandom_range(0, 63));
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_st[0] == 13) reset = ($urandom_range(0, 7) != 0);
            else               reset = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
